// File: rtl/myproject_mul_mac_pipe_if.sv
// Sample/result bundle for the pipelined MAC: clock enable, input sample with sideband, and the result.
interface myproject_mul_mac_pipe_if #(
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 26
);
  logic                         ce;
  logic                         in_valid;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         acc_en;
  logic                         acc_clr;
  logic                         out_valid;
  logic signed [dout_WIDTH-1:0] dout;
  logic                         ovf;

  modport master (
    output ce, in_valid, din0, din1, acc_en, acc_clr,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  ce, in_valid, din0, din1, acc_en, acc_clr,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/myproject_mul_mac_pipe.sv
// Pipelined signed multiplier with optional saturating accumulate in the final stage.
// Sideband (valid, acc_en, acc_clr) shifts alongside the data; ce freezes everything.
module myproject_mul_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 26
) (
  input logic ap_clk,
  input logic ap_rst,
  myproject_mul_mac_pipe_if.slave bus
);
  localparam int P   = din0_WIDTH + din1_WIDTH;
  localparam int DW  = dout_WIDTH;
  localparam int S   = ((P > DW) ? P : DW) + 1;
  localparam int NSB = NUM_STAGE - 1;
  localparam int NPR = NUM_STAGE - 2;

  localparam logic signed [S-1:0] SAT_MAX = {{(S-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [S-1:0] SAT_MIN = {{(S-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic w_unused_id;
  assign w_unused_id = ^ID;

  logic signed [din0_WIDTH-1:0] r_a;
  logic signed [din1_WIDTH-1:0] r_b;
  logic [NSB-1:0]               r_vld;
  logic [NSB-1:0]               r_en;
  logic [NSB-1:0]               r_clr;
  logic signed [P-1:0]          w_prod;
  logic signed [P-1:0]          w_fin_prod;

  logic                         r_out_valid;
  logic signed [DW-1:0]         r_dout;
  logic                         r_ovf;

  // Index 0 is stage 1; index NSB-1 feeds the output/accumulator stage.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_vld <= '0;
      r_en  <= '0;
      r_clr <= '0;
    end else if (bus.ce) begin
      r_a      <= bus.din0;
      r_b      <= bus.din1;
      r_vld[0] <= bus.in_valid;
      r_en[0]  <= bus.acc_en;
      r_clr[0] <= bus.acc_clr;
      for (int i = 1; i < NSB; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_en[i]  <= r_en[i-1];
        r_clr[i] <= r_clr[i-1];
      end
    end
  end

  assign w_prod = P'(r_a) * P'(r_b);

  generate
    if (NPR == 0) begin : g_no_prod_pipe
      assign w_fin_prod = w_prod;
    end else begin : g_prod_pipe
      logic signed [P-1:0] r_prod [NPR];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 0; i < NPR; i++) r_prod[i] <= '0;
        end else if (bus.ce) begin
          r_prod[0] <= w_prod;
          for (int i = 1; i < NPR; i++) r_prod[i] <= r_prod[i-1];
        end
      end

      assign w_fin_prod = r_prod[NPR-1];
    end
  endgenerate

  logic                 w_acc;
  logic signed [S-1:0]  w_sum;
  logic                 w_hi;
  logic                 w_lo;
  logic signed [DW-1:0] w_sat;

  // Accumulator feedback is combinational into the final register so back-to-back samples chain.
  always_comb begin
    w_acc = r_en[NSB-1] & ~r_clr[NSB-1];
    w_sum = {{(S-P){w_fin_prod[P-1]}}, w_fin_prod};
    if (w_acc) begin
      w_sum = w_sum + {{(S-DW){r_dout[DW-1]}}, r_dout};
    end
    w_hi  = (w_sum > SAT_MAX);
    w_lo  = (w_sum < SAT_MIN);
    w_sat = w_sum[DW-1:0];
    if (w_hi) begin
      w_sat = SAT_MAX[DW-1:0];
    end else if (w_lo) begin
      w_sat = SAT_MIN[DW-1:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
    end else if (bus.ce) begin
      r_out_valid <= r_vld[NSB-1];
      if (r_vld[NSB-1]) begin
        r_dout <= w_sat;
        r_ovf  <= w_hi | w_lo | (w_acc & r_ovf);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_myproject_mul_mac_pipe.sv
// Scoreboard bench for myproject_mul_mac_pipe: an arithmetic model queues expected results,
// a negedge monitor pops and compares value, overflow flag and enabled-cycle latency.
module tb_myproject_mul_mac_pipe;
  localparam int NS = 3;
  localparam int W0 = 12;
  localparam int W1 = 16;
  localparam int DW = 26;
  localparam longint SMAX = (longint'(1) << (DW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (DW-1));

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;

  myproject_mul_mac_pipe_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW)) bus();

  myproject_mul_mac_pipe #(
    .ID(1), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus(bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint dout;
    bit     ovf;
    int     due;
  } exp_t;

  exp_t   q[$];
  int     total  = 0;
  int     bad    = 0;
  int     en_cnt = 0;
  longint m_dout = 0;
  bit     m_ovf  = 0;

  always @(posedge ap_clk) if (!ap_rst && bus.ce) en_cnt++;

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted sample updates a running value in sample order.
  function automatic void model(input longint a, input longint b, input bit en, input bit clr);
    longint s;
    bit     ov;
    exp_t   e;
    s  = a * b;
    ov = 1'b0;
    if (en && !clr) begin
      s  = s + m_dout;
      ov = m_ovf;
    end
    if (s > SMAX) begin
      s  = SMAX;
      ov = 1'b1;
    end else if (s < SMIN) begin
      s  = SMIN;
      ov = 1'b1;
    end
    m_dout = s;
    m_ovf  = ov;
    e.dout = s;
    e.ovf  = ov;
    e.due  = en_cnt + NS;
    q.push_back(e);
  endfunction

  always @(negedge ap_clk) begin
    exp_t e;
    if (!ap_rst && bus.ce && bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 64'(bus.out_valid), 0);
      end else begin
        e = q.pop_front();
        check("dout", 64'(bus.dout), e.dout);
        check("ovf", 64'(bus.ovf), longint'(e.ovf));
        check("latency", 64'(en_cnt), longint'(e.due));
      end
    end
  end

  task automatic step(input bit v, input bit c, input longint a, input longint b,
                      input bit en, input bit clr);
    bus.ce       = c;
    bus.in_valid = v;
    bus.din0     = a[W0-1:0];
    bus.din1     = b[W1-1:0];
    bus.acc_en   = en;
    bus.acc_clr  = clr;
    if (c && v && !ap_rst) model(a, b, en, clr);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit c);
    ap_rst       = 1'b1;
    bus.ce       = c;
    bus.in_valid = 1'b1;
    bus.din0     = 12'sd100;
    bus.din1     = 16'sd100;
    bus.acc_en   = 1'b1;
    bus.acc_clr  = 1'b0;
    q.delete();
    m_dout = 0;
    m_ovf  = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_dout", 64'(bus.dout), 0);
    check("rst_ovf", 64'(bus.ovf), 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 20) begin
      idle();
      k++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 0);
      q.delete();
    end
    idle();
    check("hold_dout", 64'(bus.dout), m_dout);
    check("hold_ovf", 64'(bus.ovf), longint'(m_ovf));
  endtask

  function automatic longint rnd0();
    logic signed [W0-1:0] t;
    case ($urandom_range(0, 7))
      0:       t = {1'b1, {(W0-1){1'b0}}};
      1:       t = {1'b0, {(W0-1){1'b1}}};
      default: t = W0'($urandom);
    endcase
    return longint'(t);
  endfunction

  function automatic longint rnd1();
    logic signed [W1-1:0] t;
    case ($urandom_range(0, 7))
      0:       t = {1'b1, {(W1-1){1'b0}}};
      1:       t = {1'b0, {(W1-1){1'b1}}};
      default: t = W1'($urandom);
    endcase
    return longint'(t);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ce = 1'b0; bus.in_valid = 1'b0; bus.din0 = '0; bus.din1 = '0;
    bus.acc_en = 1'b0; bus.acc_clr = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    do_reset(1'b0);

    step(1, 1, 3, -5, 0, 0);
    drain();
    check("hold_minus15", 64'(bus.dout), -15);

    step(1, 1, -2048, -32768, 0, 0);
    step(1, 1, 2047, -32768, 0, 0);
    drain();

    step(1, 1, 3, -5, 1, 1);
    step(1, 1, 7, 4, 1, 0);
    drain();
    check("acc_chain", 64'(bus.dout), 13);

    step(1, 1, 1000, 16000, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1000, 16000, 1, 0);
    step(1, 1, 1, 1, 1, 1);
    drain();
    check("fresh_clr", 64'(bus.dout), 1);

    step(1, 1, 11, 13, 1, 1);
    step(1, 1, -7, 9, 1, 0);
    step(1, 0, 500, 500, 1, 1);
    step(1, 0, 400, 400, 0, 0);
    step(1, 1, 100, -3, 1, 0);
    step(0, 1, 999, 999, 1, 1);
    step(1, 1, -2048, 5, 0, 0);
    step(1, 1, 6, 6, 1, 0);
    drain();

    step(1, 1, 10, 50, 1, 1);
    drain();
    step(1, 1, 1, 1, 1, 0);
    step(1, 1, 2, 3, 0, 0);
    do_reset(1'b1);
    step(1, 1, 2, 2, 1, 0);
    drain();
    check("post_rst_acc", 64'(bus.dout), 4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(bit'($urandom_range(0, 1)));
      end else begin
        step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) != 0),
             rnd0(), rnd1(), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
